// File: rtl/arb_cycle_detect_pkg.sv
// arb_pkg: shared types and helpers for the arbitrage negative-cycle detector.
//   state_t     FSM encoding used by arb_cycle_detect (also visible on state_dbg)
//   UNREACHED   all-ones weight marking a vertex the relaxation never reached
//   get_weight / get_pred / make_vert
//               field helpers for one vertmat entry {pred, weight} at the
//               default widths (WEIGHT_W=32, PRED_W=3)
package arb_pkg;

  localparam int DEF_WEIGHT_W = 32;
  localparam int DEF_PRED_W   = 3;
  localparam int DEF_VERT_W   = DEF_PRED_W + DEF_WEIGHT_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    WALK = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [DEF_WEIGHT_W-1:0] UNREACHED = '1;

  function automatic logic [DEF_WEIGHT_W-1:0] get_weight(input logic [DEF_VERT_W-1:0] e);
    return e[DEF_WEIGHT_W-1:0];
  endfunction

  function automatic logic [DEF_PRED_W-1:0] get_pred(input logic [DEF_VERT_W-1:0] e);
    return e[DEF_VERT_W-1:DEF_WEIGHT_W];
  endfunction

  function automatic logic [DEF_VERT_W-1:0] make_vert(input logic [DEF_PRED_W-1:0] pred,
                                                      input logic [DEF_WEIGHT_W-1:0] weight);
    return {pred, weight};
  endfunction

endpackage

// File: rtl/arb_cycle_detect_relax_check.sv
// relax_check: combinational Bellman-Ford relaxation test for one edge.
//   w_src      signed weight of the edge source vertex
//   w_dst      signed weight of the edge destination vertex
//   edge_w     signed edge weight (0 means no edge)
//   violation  1 when the edge exists, the source is reached, and
//              w_src + edge_w < w_dst
module relax_check #(
  parameter int WEIGHT_W = 32
) (
  input  logic [WEIGHT_W-1:0] w_src,
  input  logic [WEIGHT_W-1:0] w_dst,
  input  logic [WEIGHT_W-1:0] edge_w,
  output logic                violation
);

  // One extra bit of headroom so the sum of two WEIGHT_W values never wraps.
  logic signed [WEIGHT_W:0] sum_ext;
  logic signed [WEIGHT_W:0] dst_ext;

  always_comb begin
    sum_ext   = $signed({w_src[WEIGHT_W-1], w_src}) + $signed({edge_w[WEIGHT_W-1], edge_w});
    dst_ext   = $signed({w_dst[WEIGHT_W-1], w_dst});
    violation = (edge_w != '0) && (w_src != {WEIGHT_W{1'b1}}) && (sum_ext < dst_ext);
  end

endmodule

// File: rtl/arb_cycle_detect.sv
// arb_cycle_detect: negative-cycle detection and cycle streaming after
// Bellman-Ford relaxation.
//   clk, cycle_reset  clock and synchronous active-high reset
//   start             upstream relaxation done; sampled only in IDLE
//   adjmat            NODES*NODES signed edge weights, entry [src][dst] at
//                     bit offset (src*NODES+dst)*WEIGHT_W; 0 = no edge
//   vertmat           NODES entries of {pred, weight}, entry n at n*(PRED_W+WEIGHT_W)
//   path_node/valid/ready/last
//                     cycle vertex stream to the order generator
//   cycle_found, cycle_len, cycle_done
//                     result; held in DONE until reset
//   state_dbg         current FSM state
module arb_cycle_detect
  import arb_pkg::*;
#(
  parameter int NODES    = 8,
  parameter int WEIGHT_W = 32,
  parameter int PRED_W   = 3
) (
  input  logic                                 clk,
  input  logic                                 cycle_reset,
  input  logic                                 start,
  input  logic [NODES*NODES*WEIGHT_W-1:0]      adjmat,
  input  logic [NODES*(PRED_W+WEIGHT_W)-1:0]   vertmat,
  output logic [PRED_W-1:0]                    path_node,
  output logic                                 path_valid,
  input  logic                                 path_ready,
  output logic                                 path_last,
  output logic                                 cycle_found,
  output logic [PRED_W:0]                      cycle_len,
  output logic                                 cycle_done,
  output state_t                               state_dbg
);

  localparam int VW    = PRED_W + WEIGHT_W;
  localparam int SLOTS = 2 ** PRED_W;
  localparam logic [PRED_W-1:0] LAST_IDX  = PRED_W'(NODES - 1);
  localparam logic [PRED_W:0]   NODES_CNT = (PRED_W + 1)'(NODES);

  state_t              state;
  logic [PRED_W-1:0]   i, j, v, c;
  logic [PRED_W:0]     walk_cnt, len;
  logic [PRED_W:0]     len_next;
  logic                violation;

  // Unpacked views of the flat matrices; slots beyond NODES read as zero so
  // every PRED_W-wide index is in range.
  logic [WEIGHT_W-1:0] w_arr   [SLOTS];
  logic [PRED_W-1:0]   p_arr   [SLOTS];
  logic [WEIGHT_W-1:0] adj_arr [SLOTS][SLOTS];

  always_comb begin
    for (int a = 0; a < SLOTS; a++) begin
      w_arr[a] = '0;
      p_arr[a] = '0;
      for (int b = 0; b < SLOTS; b++) adj_arr[a][b] = '0;
    end
    for (int a = 0; a < NODES; a++) begin
      w_arr[a] = vertmat[a*VW +: WEIGHT_W];
      p_arr[a] = vertmat[a*VW + WEIGHT_W +: PRED_W];
      for (int b = 0; b < NODES; b++) adj_arr[a][b] = adjmat[(a*NODES + b)*WEIGHT_W +: WEIGHT_W];
    end
  end

  relax_check #(.WEIGHT_W(WEIGHT_W)) u_relax (
    .w_src    (w_arr[i]),
    .w_dst    (w_arr[j]),
    .edge_w   (adj_arr[i][j]),
    .violation(violation)
  );

  assign len_next  = len + 1'b1;
  assign state_dbg = state;

  // Stream handshake: a beat transfers on a rising edge where path_valid and
  // path_ready are both 1. Once path_valid is raised, path_node and path_last
  // stay constant and path_valid stays high until that transfer happens.
  // path_node doubles as the traversal cursor during EMIT.
  always_ff @(posedge clk) begin
    if (cycle_reset) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      v           <= '0;
      c           <= '0;
      walk_cnt    <= '0;
      len         <= '0;
      path_node   <= '0;
      path_valid  <= 1'b0;
      path_last   <= 1'b0;
      cycle_found <= 1'b0;
      cycle_len   <= '0;
      cycle_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            i     <= '0;
            j     <= '0;
          end
        end
        SCAN: begin
          if (violation) begin
            v        <= j;
            walk_cnt <= '0;
            state    <= WALK;
          end else if (i == LAST_IDX && j == LAST_IDX) begin
            cycle_found <= 1'b0;
            cycle_done  <= 1'b1;
            state       <= DONE;
          end else if (j == LAST_IDX) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        WALK: begin
          // NODES predecessor hops from a violating vertex always land on the cycle.
          if (walk_cnt == NODES_CNT) begin
            c          <= v;
            path_node  <= v;
            path_last  <= 1'b0;
            path_valid <= 1'b1;
            len        <= '0;
            state      <= EMIT;
          end else begin
            v        <= p_arr[v];
            walk_cnt <= walk_cnt + 1'b1;
          end
        end
        EMIT: begin
          if (path_ready) begin
            if (path_last) begin
              path_valid  <= 1'b0;
              path_last   <= 1'b0;
              cycle_len   <= len;
              cycle_found <= 1'b1;
              cycle_done  <= 1'b1;
              state       <= DONE;
            end else begin
              len <= len_next;
              // Close the cycle on returning to c, or force it once NODES
              // vertices have gone out without a return.
              if (p_arr[path_node] == c || len_next == NODES_CNT) begin
                path_node <= c;
                path_last <= 1'b1;
              end else begin
                path_node <= p_arr[path_node];
              end
            end
          end
        end
        DONE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_cycle_detect.sv
module tb_arb_cycle_detect;
  import arb_pkg::*;

  localparam int NODES    = 4;
  localparam int WEIGHT_W = 32;
  localparam int PRED_W   = 3;
  localparam int VW       = PRED_W + WEIGHT_W;

  // ---------------- clock / reset / DUT ----------------
  logic                               clk = 1'b0;
  logic                               cycle_reset;
  logic                               start;
  logic [NODES*NODES*WEIGHT_W-1:0]    adjmat;
  logic [NODES*VW-1:0]                vertmat;
  logic [PRED_W-1:0]                  path_node;
  logic                               path_valid;
  logic                               path_ready;
  logic                               path_last;
  logic                               cycle_found;
  logic [PRED_W:0]                    cycle_len;
  logic                               cycle_done;
  state_t                             state_dbg;

  always #5 clk = ~clk;

  arb_cycle_detect #(.NODES(NODES), .WEIGHT_W(WEIGHT_W), .PRED_W(PRED_W)) dut (
    .clk        (clk),
    .cycle_reset(cycle_reset),
    .start      (start),
    .adjmat     (adjmat),
    .vertmat    (vertmat),
    .path_node  (path_node),
    .path_valid (path_valid),
    .path_ready (path_ready),
    .path_last  (path_last),
    .cycle_found(cycle_found),
    .cycle_len  (cycle_len),
    .cycle_done (cycle_done),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];   // {last, node} of each expected beat

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string                           name;
    logic [NODES*NODES*WEIGHT_W-1:0] adj;
    logic [NODES*VW-1:0]             vert;
    logic [3:0]                      ready_pat;  // bit k = ready on k-th valid cycle (mod 4)
    int                              budget;     // cycles allowed from start to cycle_done
    logic                            exp_found;
    logic [PRED_W:0]                 exp_len;
    int                              n_beats;
    logic [5:0][3:0]                 beats;
  } vec_t;

  vec_t vecs[5];
  logic [NODES*NODES*WEIGHT_W-1:0] adj_v;
  logic [NODES*VW-1:0]             vert_v;

  task automatic clr();
    adj_v  = '0;
    vert_v = '0;
  endtask

  task automatic set_adj(input int s, input int d, input logic [31:0] w);
    adj_v[(s*NODES + d)*WEIGHT_W +: WEIGHT_W] = w;
  endtask

  task automatic set_vert(input int n, input int p, input logic [31:0] w);
    vert_v[n*VW +: VW] = make_vert(3'(p), w);
  endtask

  task automatic build_triangle();
    clr();
    set_adj(0, 1, -32'sd1);
    set_adj(1, 2, -32'sd1);
    set_adj(2, 0, -32'sd1);
    set_vert(0, 2, -32'sd5);
    set_vert(1, 0, -32'sd4);
    set_vert(2, 1, -32'sd5);
    set_vert(3, 0, 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    cycle_reset = 1'b1;
    start       = 1'b0;
    path_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({path_valid, path_last, cycle_found, cycle_done, cycle_len, path_node}), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    cycle_reset = 1'b0;
  endtask

  // Runs until cycle_done (or stop_beats accepted beats); drives path_ready
  // from pat, checks each accepted beat against exp_q and stall stability.
  task automatic collect(input logic [3:0] pat, input int budget, input int stop_beats,
                         output int cycles);
    int rcnt  = 0;
    int beats = 0;
    bit stall = 1'b0;
    logic [PRED_W-1:0] hn = '0;
    logic hl = 1'b0;
    logic [3:0] e;
    cycles = budget + 1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (stall) check("stall_hold", 32'({path_valid, path_last, path_node}), 32'({1'b1, hl, hn}));
      if (cycle_done) begin
        cycles     = cyc + 1;
        path_ready = 1'b0;
        break;
      end
      if (path_valid) begin
        path_ready = pat[2'(rcnt)];
        rcnt++;
        if (path_ready) begin
          stall = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("beat", 32'({path_last, path_node}), 32'(e));
          end
          beats++;
          if (stop_beats > 0 && beats == stop_beats) begin
            cycles = cyc + 1;
            break;
          end
        end else begin
          stall = 1'b1;
          hn    = path_node;
          hl    = path_last;
        end
      end else begin
        path_ready = 1'b0;
      end
    end
  endtask

  task automatic run_vec(input vec_t t);
    int cycles;
    do_reset();
    adjmat  = t.adj;
    vertmat = t.vert;
    exp_q.delete();
    for (int k = 0; k < t.n_beats; k++) exp_q.push_back(t.beats[k]);
    start = 1'b1;   // held high like the upstream done flag
    collect(t.ready_pat, t.budget, 0, cycles);
    $display("vector %s: %0d cycles", t.name, cycles);
    check({t.name, "_done"}, 32'(cycle_done), 32'd1);
    check({t.name, "_in_budget"}, 32'(cycles <= t.budget), 32'd1);
    check({t.name, "_found"}, 32'(cycle_found), 32'(t.exp_found));
    check({t.name, "_len"}, 32'(cycle_len), 32'(t.exp_len));
    check({t.name, "_all_beats"}, 32'(exp_q.size()), 32'd0);
    // DONE must hold with start still high.
    repeat (3) @(negedge clk);
    check({t.name, "_done_hold"}, 32'({cycle_done, path_valid, cycle_found}), 32'({1'b1, 1'b0, t.exp_found}));
    check({t.name, "_done_state"}, 32'(state_dbg), 32'(DONE));
  endtask

  // ---------------- test ----------------
  initial begin
    int cycles;
    cycle_reset = 1'b1;
    start       = 1'b0;
    path_ready  = 1'b0;
    adjmat      = '0;
    vertmat     = '0;

    // 1: consistent weights, no cycle
    clr();
    set_adj(0, 1, 32'd1);
    set_adj(1, 2, 32'd1);
    set_adj(2, 3, 32'd1);
    for (int n = 0; n < NODES; n++) set_vert(n, 0, 32'(n));
    vecs[0] = '{name: "consistent", adj: adj_v, vert: vert_v, ready_pat: 4'b1111, budget: 18,
                exp_found: 1'b0, exp_len: '0, n_beats: 0, beats: '0};

    // 2: triangle 0->1->2->0, violation at (0,1)
    build_triangle();
    vecs[1] = '{name: "triangle", adj: adj_v, vert: vert_v, ready_pat: 4'b1111, budget: 100,
                exp_found: 1'b1, exp_len: 4'd3, n_beats: 4,
                beats: {4'h0, 4'h0, 4'h8, 4'h1, 4'h2, 4'h0}};

    // 3: triangle under backpressure 1-0-0-1
    vecs[2] = vecs[1];
    vecs[2].name      = "triangle_bp";
    vecs[2].ready_pat = 4'b1001;

    // 4: self-loop on vertex 3
    clr();
    set_adj(3, 3, -32'sd2);
    set_vert(3, 3, 32'd0);
    vecs[3] = '{name: "self_loop", adj: adj_v, vert: vert_v, ready_pat: 4'b1111, budget: 100,
                exp_found: 1'b1, exp_len: 4'd1, n_beats: 2,
                beats: {4'h0, 4'h0, 4'h0, 4'h0, 4'hB, 4'h3}};

    // 5: negative edge out of an unreached source
    clr();
    set_adj(0, 1, -32'sd100);
    set_vert(0, 0, 32'hFFFF_FFFF);
    vecs[4] = '{name: "unreached", adj: adj_v, vert: vert_v, ready_pat: 4'b1111, budget: 18,
                exp_found: 1'b0, exp_len: '0, n_beats: 0, beats: '0};

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // 6: reset after the second beat of the triangle, then replay
    do_reset();
    build_triangle();
    adjmat  = adj_v;
    vertmat = vert_v;
    exp_q.delete();
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h2);
    start = 1'b1;
    collect(4'b1111, 100, 2, cycles);
    check("mid_emit_reached", 32'(exp_q.size()), 32'd0);
    @(negedge clk);              // second beat transfers on this edge
    check("third_beat_up", 32'({path_valid, path_node}), 32'({1'b1, 3'd1}));
    cycle_reset = 1'b1;
    path_ready  = 1'b0;
    @(negedge clk);
    check("abort_outputs", 32'({path_valid, path_last, cycle_found, cycle_done, cycle_len, path_node}), 32'd0);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    cycle_reset = 1'b0;
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h2);
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h8);
    collect(4'b1111, 100, 0, cycles);
    check("replay_done", 32'(cycle_done), 32'd1);
    check("replay_found_len", 32'({cycle_found, cycle_len}), 32'({1'b1, 4'd3}));
    check("replay_all_beats", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
